// File: rtl/fxp_pkg.sv
// Shared fixed-point constants and trainer state encoding for the XOR/OR perceptron.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fxp_pkg;
    localparam int          TAM_DEF = 16;
    localparam int          FRAC    = 12;
    localparam logic [15:0] ONE     = 16'h1000;
    localparam logic [14:0] MAG_MAX = 15'h7FFF;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FWD,
        UPD,
        CHECK,
        DONE
    } state_t;
endpackage

// File: rtl/sm_add_sat.sv
// Sign-magnitude saturating adder; magnitude clamps at all-ones, zero is always +0.
// Latency: combinational.
// Backpressure: none.
module sm_add_sat #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);
    logic         sa;
    logic         sb;
    logic [W-2:0] ma;
    logic [W-2:0] mb;
    logic [W-1:0] sum;
    logic         sign;
    logic [W-2:0] mag;

    assign sa = a[W-1];
    assign sb = b[W-1];
    assign ma = a[W-2:0];
    assign mb = b[W-2:0];

    // Same signs add magnitudes with clamp; opposite signs subtract the smaller from the larger.
    always_comb begin
        sign = 1'b0;
        mag  = '0;
        sum  = {1'b0, ma} + {1'b0, mb};
        if (sa == sb) begin
            sign = sa;
            mag  = sum[W-1] ? {(W-1){1'b1}} : sum[W-2:0];
        end else if (ma >= mb) begin
            sign = sa;
            mag  = ma - mb;
        end else begin
            sign = sb;
            mag  = mb - ma;
        end
        y = (mag == '0) ? '0 : {sign, mag};
    end
endmodule

// File: rtl/perceptron_trainer_fixed.sv
// Perceptron trainer over a 4-sample truth table; optional err_cnt output under PT_ERR_COUNT_EN.
// Latency: done pulses 2 + 9*epochs cycles after the edge that samples start.
// Backpressure: none; start is only honoured in IDLE and ignored while busy.
module perceptron_trainer_fixed
    import fxp_pkg::*;
#(
    parameter int TAM        = 16,
    parameter int ETA_SHIFT  = 1,
    parameter int MAX_EPOCHS = 15,
    parameter int EPW        = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [3:0][TAM-1:0]  in1,
    input  logic [3:0][TAM-1:0]  in2,
    input  logic [3:0][TAM-1:0]  d,
    input  logic [TAM-1:0]       w0_init,
    input  logic [TAM-1:0]       w1_init,
    input  logic [TAM-1:0]       w2_init,
    output logic [TAM-1:0]       w0,
    output logic [TAM-1:0]       w1,
    output logic [TAM-1:0]       w2,
    output logic                 busy,
    output logic                 done,
    output logic                 converged,
    output logic [EPW-1:0]       epochs
`ifdef PT_ERR_COUNT_EN
    ,
    output logic [2:0]           err_cnt
`endif
);
    // Bias step is 1.0 scaled by the learning rate.
    localparam logic [TAM-2:0] ETA_MAG = (TAM-1)'(ONE >> ETA_SHIFT);

    state_t         state;
    state_t         state_nxt;
    logic [1:0]     idx;
    logic           err_flag;
    logic [TAM-1:0] net_q;
`ifdef PT_ERR_COUNT_EN
    logic [2:0]     errs;
`endif

    logic [TAM-1:0] x1;
    logic [TAM-1:0] x2;
    logic [TAM-1:0] tgt;
    logic [TAM-1:0] p1;
    logic [TAM-1:0] p2;
    logic           y_pos;
    logic           d_pos;
    logic           mis;
    logic           neg;
    logic           last_epoch;
    logic [TAM-1:0] add0_a, add0_b, add0_y;
    logic [TAM-1:0] add1_a, add1_b, add1_y;
    logic [TAM-1:0] add2_a, add2_b, add2_y;

    // Q1.3.12 product: keep bits [FRAC+TAM-2:FRAC], clamp if anything above is set.
    function automatic logic [TAM-1:0] sm_mul(input logic [TAM-1:0] a, input logic [TAM-1:0] b);
        logic [2*TAM-1:0] prod;
        logic [TAM-2:0]   mag;
        prod = {{(TAM+1){1'b0}}, a[TAM-2:0]} * {{(TAM+1){1'b0}}, b[TAM-2:0]};
        if (|prod[2*TAM-1:FRAC+TAM-1]) mag = '1;
        else                           mag = prod[FRAC+TAM-2:FRAC];
        return (mag == '0) ? '0 : {a[TAM-1] ^ b[TAM-1], mag};
    endfunction

    assign x1    = in1[idx];
    assign x2    = in2[idx];
    assign tgt   = d[idx];
    assign p1    = sm_mul(w1, x1);
    assign p2    = sm_mul(w2, x2);
    assign y_pos = !net_q[TAM-1] && (net_q[TAM-2:0] != '0);
    assign d_pos = !tgt[TAM-1] && (tgt[TAM-2:0] != '0);
    assign mis   = (y_pos != d_pos);
    // Error is -1 exactly when the perceptron fired but the target was 0.
    assign neg   = y_pos;
    assign last_epoch = (epochs == EPW'(MAX_EPOCHS - 1));
    assign busy  = (state == LOAD) || (state == FWD) || (state == UPD) || (state == CHECK);

    // Adders are shared: FWD chains w0+p1+p2 into net, UPD applies the three weight steps.
    always_comb begin
        add0_a = w0;
        add0_b = {neg, ETA_MAG};
        add1_a = w1;
        add1_b = {x1[TAM-1] ^ neg, x1[TAM-2:0] >> ETA_SHIFT};
        add2_a = w2;
        add2_b = {x2[TAM-1] ^ neg, x2[TAM-2:0] >> ETA_SHIFT};
        if (state == FWD) begin
            add0_b = p1;
            add1_a = add0_y;
            add1_b = p2;
        end
    end

    sm_add_sat #(.W(TAM)) u_add0 (.a(add0_a), .b(add0_b), .y(add0_y));
    sm_add_sat #(.W(TAM)) u_add1 (.a(add1_a), .b(add1_b), .y(add1_y));
    sm_add_sat #(.W(TAM)) u_add2 (.a(add2_a), .b(add2_b), .y(add2_y));

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state sequencing: one FWD/UPD pair per sample, CHECK closes each epoch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = LOAD;
            LOAD:    state_nxt = FWD;
            FWD:     state_nxt = UPD;
            UPD:     state_nxt = (idx == 2'd3) ? CHECK : FWD;
            CHECK:   state_nxt = (!err_flag || last_epoch) ? DONE : FWD;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath and status registers; done is registered so it trails the DONE state by one cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w0        <= '0;
            w1        <= '0;
            w2        <= '0;
            idx       <= '0;
            err_flag  <= 1'b0;
            net_q     <= '0;
            done      <= 1'b0;
            converged <= 1'b0;
            epochs    <= '0;
`ifdef PT_ERR_COUNT_EN
            errs      <= '0;
            err_cnt   <= '0;
`endif
        end else begin
            done <= (state == DONE);
            case (state)
                LOAD: begin
                    w0        <= w0_init;
                    w1        <= w1_init;
                    w2        <= w2_init;
                    idx       <= '0;
                    epochs    <= '0;
                    err_flag  <= 1'b0;
                    converged <= 1'b0;
`ifdef PT_ERR_COUNT_EN
                    errs      <= '0;
`endif
                end
                FWD: net_q <= add1_y;
                UPD: begin
                    if (mis) begin
                        w0       <= add0_y;
                        w1       <= add1_y;
                        w2       <= add2_y;
                        err_flag <= 1'b1;
`ifdef PT_ERR_COUNT_EN
                        errs     <= errs + 3'd1;
`endif
                    end
                    idx <= idx + 2'd1;
                end
                CHECK: begin
                    epochs    <= epochs + EPW'(1);
                    converged <= !err_flag;
                    err_flag  <= 1'b0;
                    idx       <= '0;
`ifdef PT_ERR_COUNT_EN
                    err_cnt   <= errs;
                    errs      <= '0;
`endif
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_perceptron_trainer_fixed.sv
module tb_perceptron_trainer_fixed;
    localparam int ETA  = 1;
    localparam int MAXE = 15;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [3:0][15:0] in1 = '0;
    logic [3:0][15:0] in2 = '0;
    logic [3:0][15:0] d = '0;
    logic [15:0]      w0_init = '0, w1_init = '0, w2_init = '0;
    logic [15:0]      w0, w1, w2;
    logic             busy, done, converged;
    logic [3:0]       epochs;
`ifdef PT_ERR_COUNT_EN
    logic [2:0]       err_cnt;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    // reference results
    logic [15:0] m_w0, m_w1, m_w2;
    int          m_conv, m_ep, m_last_errs, m_first_errs;
    int          cyc;
    int          ec1;

    always #5 clk = ~clk;

    perceptron_trainer_fixed #(
        .TAM(16), .ETA_SHIFT(ETA), .MAX_EPOCHS(MAXE), .EPW(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .in1(in1), .in2(in2), .d(d),
        .w0_init(w0_init), .w1_init(w1_init), .w2_init(w2_init),
        .w0(w0), .w1(w1), .w2(w2),
        .busy(busy), .done(done), .converged(converged), .epochs(epochs)
`ifdef PT_ERR_COUNT_EN
        , .err_cnt(err_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // ---- reference model: real-valued arithmetic in units of 2^-12 ----
    function automatic int to_i(input logic [15:0] x);
        return x[15] ? -int'(x[14:0]) : int'(x[14:0]);
    endfunction

    function automatic logic [15:0] to_sm(input int v);
        if (v < 0) return {1'b1, 15'(-v)};
        return {1'b0, 15'(v)};
    endfunction

    function automatic int sat(input int v);
        if (v > 32767)  return 32767;
        if (v < -32767) return -32767;
        return v;
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int mul(input int a, input int b);
        int m;
        m = sat((iabs(a) * iabs(b)) / 4096);
        return ((a < 0) != (b < 0)) ? -m : m;
    endfunction

    function automatic int step(input int x);
        int m;
        m = iabs(x) / (1 << ETA);
        return (x < 0) ? -m : m;
    endfunction

    task automatic model_run();
        int a0, a1, a2, net, x1, x2, sg, errs;
        a0 = to_i(w0_init); a1 = to_i(w1_init); a2 = to_i(w2_init);
        m_conv = 0; m_ep = 0; m_last_errs = 0; m_first_errs = 0;
        for (int e = 1; e <= MAXE; e++) begin
            errs = 0;
            for (int k = 0; k < 4; k++) begin
                x1  = to_i(in1[k]);
                x2  = to_i(in2[k]);
                net = sat(sat(a0 + mul(a1, x1)) + mul(a2, x2));
                if ((net > 0) != (to_i(d[k]) > 0)) begin
                    sg = (to_i(d[k]) > 0) ? 1 : -1;
                    a0 = sat(a0 + sg * (4096 / (1 << ETA)));
                    a1 = sat(a1 + sg * step(x1));
                    a2 = sat(a2 + sg * step(x2));
                    errs++;
                end
            end
            m_ep = e;
            m_last_errs = errs;
            if (e == 1) m_first_errs = errs;
            if (errs == 0) begin
                m_conv = 1;
                break;
            end
        end
        m_w0 = to_sm(a0); m_w1 = to_sm(a1); m_w2 = to_sm(a2);
    endtask

    // ---- stimulus ----
    task automatic run(input bit noise);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        cyc = 0;
        ec1 = -1;
        while (cyc < 400) begin
            @(posedge clk); cyc++; #1;
`ifdef PT_ERR_COUNT_EN
            if (cyc == 10) ec1 = err_cnt;
`endif
            if (done) break;
            start = noise && ((cyc % 5) == 2);
        end
        start = 1'b0;
        chk("done_seen", done, 1);
        chk("busy_at_done", busy, 0);
    endtask

    task automatic check_model(input string tag);
        model_run();
        chk({tag, "_w0"}, w0, m_w0);
        chk({tag, "_w1"}, w1, m_w1);
        chk({tag, "_w2"}, w2, m_w2);
        chk({tag, "_conv"}, converged, m_conv);
        chk({tag, "_epochs"}, epochs, m_ep);
        chk({tag, "_latency"}, cyc, 2 + 9 * m_ep);
`ifdef PT_ERR_COUNT_EN
        chk({tag, "_errcnt_done"}, err_cnt, m_last_errs);
        chk({tag, "_errcnt_ep1"}, ec1, m_first_errs);
`endif
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, done, 0);
    endtask

    task automatic set_tt(input logic [3:0] tv);
        for (int k = 0; k < 4; k++) begin
            in1[k] = k[0] ? 16'h1000 : 16'h0000;
            in2[k] = k[1] ? 16'h1000 : 16'h0000;
            d[k]   = tv[k] ? 16'h1000 : 16'h0000;
        end
    endtask

    function automatic logic [15:0] rnd_sm(input int maxmag);
        int m;
        m = $urandom_range(maxmag, 0);
        if (m == 0) return 16'h0000;
        return {1'($urandom_range(1, 0)), 15'(m)};
    endfunction

    initial begin
        int cyc_ref;
        bit seen;
        // reset state
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_w0", w0, 0);
        chk("rst_w1", w1, 0);
        chk("rst_w2", w2, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_conv", converged, 0);
        chk("rst_epochs", epochs, 0);

        // OR training
        w0_init = 16'h8800; w1_init = 16'h0800; w2_init = 16'h0800;
        set_tt(4'b1110);
        run(1'b0);
        chk("or_w0", w0, 16'h0000);
        chk("or_w1", w1, 16'h1000);
        chk("or_w2", w2, 16'h0800);
        chk("or_conv", converged, 1);
        chk("or_epochs", epochs, 2);
        chk("or_latency", cyc, 20);
        check_model("or");

        // OR again with start pulses while busy: identical results and timing
        run(1'b1);
        chk("noise_latency", cyc, 20);
        check_model("or_noise");

        // XOR never converges
        set_tt(4'b0110);
        run(1'b0);
        chk("xor_conv", converged, 0);
        chk("xor_epochs", epochs, 15);
        chk("xor_latency", cyc, 137);
        check_model("xor");

        // saturation: w1 clamps at -max, never wraps
        w0_init = 16'h7FF0; w1_init = 16'hFF00; w2_init = 16'h0000;
        for (int k = 0; k < 4; k++) begin
            in1[k] = 16'h1000; in2[k] = 16'h0000; d[k] = 16'h0000;
        end
        run(1'b0);
        chk("sat_w1", w1, 16'hFFFF);
        check_model("sat");

        // reset in the middle of epoch 2 of an OR run
        w0_init = 16'h8800; w1_init = 16'h0800; w2_init = 16'h0800;
        set_tt(4'b1110);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("abort_w0", w0, 0);
        chk("abort_w1", w1, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_conv", converged, 0);
        chk("abort_epochs", epochs, 0);
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (done || busy) seen = 1'b1;
        end
        chk("abort_no_done", seen, 0);
        run(1'b0);
        chk("restart_latency", cyc, 20);
        check_model("restart");

        // randomized runs against the reference model
        for (int r = 0; r < 10; r++) begin
            int mx;
            mx = (r % 3 == 0) ? 32767 : 12288;
            w0_init = rnd_sm(mx); w1_init = rnd_sm(mx); w2_init = rnd_sm(mx);
            for (int k = 0; k < 4; k++) begin
                in1[k] = rnd_sm(mx);
                in2[k] = rnd_sm(mx);
                d[k]   = $urandom_range(1, 0) ? 16'h1000 : 16'h0000;
            end
            run(r[0]);
            check_model($sformatf("rnd%0d", r));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
